// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - hazard inputs and pipeline-register control bundle for pipeline_ctrl
interface pipeline_ctrl_if;
  logic [4:0]  ID_rs1;
  logic [4:0]  ID_rs2;
  logic [2:0]  ID_ValidReg;
  logic [4:0]  EX_rd;
  logic [2:0]  EX_ValidReg;
  logic        EX_MemRead;
  logic        EX_redirect;
  logic        IF_ready;
  logic        MEM_req;
  logic        MEM_ready;
  logic        pc_en;
  logic        IF_ID_en;
  logic        ID_EX_en;
  logic        EX_MEM_en;
  logic        MEM_WB_en;
  logic        IF_ID_flush;
  logic        ID_EX_flush;
  logic        MEM_WB_bubble;
  logic [1:0]  state;
  logic        mem_fault;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic [31:0] lu_cnt;

  modport master (
    output ID_rs1, ID_rs2, ID_ValidReg, EX_rd, EX_ValidReg, EX_MemRead,
           EX_redirect, IF_ready, MEM_req, MEM_ready,
    input  pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en,
           IF_ID_flush, ID_EX_flush, MEM_WB_bubble,
           state, mem_fault, stall_cnt, flush_cnt, lu_cnt
  );

  modport slave (
    input  ID_rs1, ID_rs2, ID_ValidReg, EX_rd, EX_ValidReg, EX_MemRead,
           EX_redirect, IF_ready, MEM_req, MEM_ready,
    output pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en,
           IF_ID_flush, ID_EX_flush, MEM_WB_bubble,
           state, mem_fault, stall_cnt, flush_cnt, lu_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - RV100 stall/flush sequencer with data-memory timeout FSM
// Optional performance counters: define PIPECTRL_PERF_EN.
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  pipeline_ctrl_if.slave bus
);

  localparam int WCW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           mem_fault_q, mem_fault_d;

  logic mem_stall, load_use, timeout;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, mem_wb_bubble;

  assign mem_stall = bus.MEM_req & ~bus.MEM_ready;
  assign load_use  = bus.EX_MemRead & bus.EX_ValidReg[0] & (bus.EX_rd != 5'd0) &
                     ((bus.ID_ValidReg[1] & (bus.ID_rs1 == bus.EX_rd)) |
                      (bus.ID_ValidReg[2] & (bus.ID_rs2 == bus.EX_rd)));

  // Fault fires on the cycle that would be the N-th consecutive stall.
  always_comb begin
    timeout = 1'b0;
    if ((MEM_TIMEOUT != 0) && mem_stall && (wait_cnt_q == WCW'(MEM_TIMEOUT - 1)))
      timeout = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_fault_q <= mem_fault_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    if (state_q != FAULT) begin
      if (timeout)        state_d = FAULT;
      else if (mem_stall) state_d = MEM_WAIT;
      else                state_d = RUN;
      if (mem_stall) wait_cnt_d = wait_cnt_q + WCW'(1);
    end
    mem_fault_d = mem_fault_q | (state_d == FAULT);
  end

  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    if (state_q == FAULT) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (mem_stall) begin
      // EX is frozen, so a pending redirect simply re-presents after release.
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (bus.EX_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (!bus.IF_ready) begin
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
    end
  end

  assign bus.pc_en         = pc_en;
  assign bus.IF_ID_en      = if_id_en;
  assign bus.ID_EX_en      = id_ex_en;
  assign bus.EX_MEM_en     = ex_mem_en;
  assign bus.MEM_WB_en     = mem_wb_en;
  assign bus.IF_ID_flush   = if_id_flush;
  assign bus.ID_EX_flush   = id_ex_flush;
  assign bus.MEM_WB_bubble = mem_wb_bubble;
  assign bus.state         = state_q;
  assign bus.mem_fault     = mem_fault_q;

`ifdef PIPECTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [31:0] lu_cnt_q, lu_cnt_d;
  logic        active, redirect_fire, lu_fire;

  assign active        = (state_q != FAULT);
  assign redirect_fire = active & ~mem_stall & bus.EX_redirect;
  assign lu_fire       = active & ~mem_stall & ~bus.EX_redirect & load_use;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, active & ~pc_en};
    flush_cnt_d = flush_cnt_q + {31'd0, redirect_fire};
    lu_cnt_d    = lu_cnt_q + {31'd0, lu_fire};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      lu_cnt_q    <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      lu_cnt_q    <= lu_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
  assign bus.lu_cnt    = lu_cnt_q;
`else
  assign bus.stall_cnt = 32'd0;
  assign bus.flush_cnt = 32'd0;
  assign bus.lu_cnt    = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl (MEM_TIMEOUT=4)
module tb_pipeline_ctrl;

`ifdef PIPECTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  pipeline_ctrl_if bus();

  pipeline_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  wire [4:0] en = {bus.pc_en, bus.IF_ID_en, bus.ID_EX_en, bus.EX_MEM_en, bus.MEM_WB_en};
  wire [2:0] fl = {bus.IF_ID_flush, bus.ID_EX_flush, bus.MEM_WB_bubble};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] pc(input int n);
    pc = PERF ? 32'(n) : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ID_rs1      = 5'd0;
    bus.ID_rs2      = 5'd0;
    bus.ID_ValidReg = 3'b000;
    bus.EX_rd       = 5'd0;
    bus.EX_ValidReg = 3'b000;
    bus.EX_MemRead  = 1'b0;
    bus.EX_redirect = 1'b0;
    bus.IF_ready    = 1'b1;
    bus.MEM_req     = 1'b0;
    bus.MEM_ready   = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [2:0] idv);
    bus.EX_MemRead  = 1'b1;
    bus.EX_ValidReg = 3'b001;
    bus.EX_rd       = rd;
    bus.ID_rs1      = 5'd5;
    bus.ID_ValidReg = idv;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", bus.state); end
    checks++; if (bus.mem_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b exp 0", bus.mem_fault); end
    checks++; if ({bus.stall_cnt, bus.flush_cnt, bus.lu_cnt} !== 96'd0) begin errors++; $display("FAIL reset_cnts: got %0d/%0d/%0d exp 0/0/0", bus.stall_cnt, bus.flush_cnt, bus.lu_cnt); end
    checks++; if (en !== 5'b11111 || fl !== 3'b000) begin errors++; $display("FAIL reset_out: got en=%b fl=%b exp en=11111 fl=000", en, fl); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use(5'd5, 3'b010);
    #1;
    checks++; if (en !== 5'b00111 || fl !== 3'b010) begin errors++; $display("FAIL lu_out: got en=%b fl=%b exp en=00111 fl=010", en, fl); end
    tick();
    idle();
    #1;
    checks++; if (en !== 5'b11111 || fl !== 3'b000) begin errors++; $display("FAIL lu_next: got en=%b fl=%b exp en=11111 fl=000", en, fl); end
    checks++; if (bus.lu_cnt !== pc(1) || bus.stall_cnt !== pc(1)) begin errors++; $display("FAIL lu_cnt: got lu=%0d stall=%0d exp lu=%0d stall=%0d", bus.lu_cnt, bus.stall_cnt, pc(1), pc(1)); end
  endtask

  task automatic test_no_hazard();
    do_reset();
    set_load_use(5'd0, 3'b010);
    bus.ID_rs1 = 5'd0;
    #1;
    checks++; if (en !== 5'b11111) begin errors++; $display("FAIL lu_rd0: got en=%b exp 11111", en); end
    set_load_use(5'd5, 3'b000);
    #1;
    checks++; if (en !== 5'b11111) begin errors++; $display("FAIL lu_rs1_unused: got en=%b exp 11111", en); end
    set_load_use(5'd9, 3'b100);
    bus.ID_rs2 = 5'd9;
    #1;
    checks++; if (en !== 5'b00111 || fl !== 3'b010) begin errors++; $display("FAIL lu_rs2: got en=%b fl=%b exp en=00111 fl=010", en, fl); end
    idle();
    bus.MEM_req   = 1'b1;
    bus.MEM_ready = 1'b1;
    #1;
    checks++; if (en !== 5'b11111 || fl !== 3'b000) begin errors++; $display("FAIL single_access: got en=%b fl=%b exp en=11111 fl=000", en, fl); end
    tick();
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL single_state: got %0d exp 0", bus.state); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    bus.MEM_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (en !== 5'b00001 || fl !== 3'b001) begin errors++; $display("FAIL mw_out%0d: got en=%b fl=%b exp en=00001 fl=001", i, en, fl); end
      tick();
      checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL mw_state%0d: got %0d exp 1", i, bus.state); end
    end
    bus.MEM_ready = 1'b1;
    #1;
    checks++; if (en !== 5'b11111 || fl !== 3'b000) begin errors++; $display("FAIL mw_release: got en=%b fl=%b exp en=11111 fl=000", en, fl); end
    tick();
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL mw_run: got %0d exp 0", bus.state); end
    checks++; if (bus.stall_cnt !== pc(3)) begin errors++; $display("FAIL mw_stall_cnt: got %0d exp %0d", bus.stall_cnt, pc(3)); end
  endtask

  task automatic test_redirect_in_stall();
    do_reset();
    bus.MEM_req     = 1'b1;
    bus.EX_redirect = 1'b1;
    #1;
    checks++; if (en !== 5'b00001 || fl !== 3'b001) begin errors++; $display("FAIL rs_stalled: got en=%b fl=%b exp en=00001 fl=001", en, fl); end
    tick();
    bus.MEM_ready = 1'b1;
    #1;
    checks++; if (en !== 5'b11111 || fl !== 3'b110) begin errors++; $display("FAIL rs_release: got en=%b fl=%b exp en=11111 fl=110", en, fl); end
    tick();
    checks++; if (bus.flush_cnt !== pc(1) || bus.stall_cnt !== pc(1)) begin errors++; $display("FAIL rs_cnts: got flush=%0d stall=%0d exp %0d/%0d", bus.flush_cnt, bus.stall_cnt, pc(1), pc(1)); end
  endtask

  task automatic test_timeout();
    do_reset();
    bus.MEM_req = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (bus.state !== 2'd1 || bus.mem_fault !== 1'b0) begin errors++; $display("FAIL to_wait%0d: got state=%0d fault=%b exp 1/0", i, bus.state, bus.mem_fault); end
    end
    tick();
    checks++; if (bus.state !== 2'd2 || bus.mem_fault !== 1'b1) begin errors++; $display("FAIL to_fault: got state=%0d fault=%b exp 2/1", bus.state, bus.mem_fault); end
    bus.MEM_ready   = 1'b1;
    bus.EX_redirect = 1'b1;
    #1;
    checks++; if (en !== 5'b00000 || fl !== 3'b000) begin errors++; $display("FAIL to_out: got en=%b fl=%b exp en=00000 fl=000", en, fl); end
    tick();
    checks++; if (bus.state !== 2'd2 || bus.stall_cnt !== pc(4) || bus.flush_cnt !== pc(0)) begin errors++; $display("FAIL to_sticky: got state=%0d stall=%0d flush=%0d exp 2/%0d/0", bus.state, bus.stall_cnt, bus.flush_cnt, pc(4)); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (bus.state !== 2'd0 || bus.mem_fault !== 1'b0) begin errors++; $display("FAIL to_reset: got state=%0d fault=%b exp 0/0", bus.state, bus.mem_fault); end
  endtask

  task automatic test_priority();
    do_reset();
    set_load_use(5'd5, 3'b010);
    bus.EX_redirect = 1'b1;
    bus.IF_ready    = 1'b0;
    #1;
    checks++; if (en !== 5'b11111 || fl !== 3'b110) begin errors++; $display("FAIL pri_redirect: got en=%b fl=%b exp en=11111 fl=110", en, fl); end
    tick();
    checks++; if (bus.lu_cnt !== pc(0) || bus.flush_cnt !== pc(1)) begin errors++; $display("FAIL pri_cnts: got lu=%0d flush=%0d exp 0/%0d", bus.lu_cnt, bus.flush_cnt, pc(1)); end
    bus.EX_redirect = 1'b0;
    #1;
    checks++; if (en !== 5'b00111 || fl !== 3'b010) begin errors++; $display("FAIL pri_lu_ifnr: got en=%b fl=%b exp en=00111 fl=010", en, fl); end
    idle();
    bus.IF_ready = 1'b0;
    #1;
    checks++; if (en !== 5'b01111 || fl !== 3'b100) begin errors++; $display("FAIL pri_ifnr: got en=%b fl=%b exp en=01111 fl=100", en, fl); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.MEM_req = 1'b1;
    tick(); tick(); tick();
    bus.MEM_req = 1'b0;
    tick();
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL b2b_gap: got %0d exp 0", bus.state); end
    bus.MEM_req = 1'b1;
    tick(); tick(); tick();
    checks++; if (bus.state !== 2'd1 || bus.mem_fault !== 1'b0) begin errors++; $display("FAIL b2b_restart: got state=%0d fault=%b exp 1/0", bus.state, bus.mem_fault); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (bus.state !== 2'd0 || bus.stall_cnt !== 32'd0) begin errors++; $display("FAIL b2b_reset: got state=%0d stall=%0d exp 0/0", bus.state, bus.stall_cnt); end
    bus.MEM_req = 1'b0;
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    idle();
    test_reset();
    test_load_use();
    test_no_hazard();
    test_mem_wait();
    test_redirect_in_stall();
    test_timeout();
    test_priority();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
